// File: rtl/zc_pkg.sv
// Shared types and helpers for the sequenced zero-count engine.
// Holds the FSM state type, default geometry, the count-width helper and
// the mod-3 residue adder used to derive the Y flag without a divider.
package zc_pkg;

    localparam int unsigned ZC_DEFAULT_W    = 16;
    localparam int unsigned ZC_DEFAULT_STEP = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } zc_state_e;

    // Bits needed to hold a count from 0 to w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // (res + val) mod 3. val is a per-slice zero count, so STEP must stay
    // at or below 15. It is first folded into 0..2 by a short fixed chain
    // of conditional subtracts, then combined with the residue by a table.
    function automatic logic [1:0] mod3_add(input logic [1:0] res, input logic [3:0] val);
        logic [3:0] v;
        logic [1:0] sum;
        v = val;
        for (int i = 0; i < 5; i++) begin
            if (v >= 4'd3) begin
                v = v - 4'd3;
            end
        end
        case ({res, v[1:0]})
            4'b00_00: sum = 2'd0;
            4'b00_01: sum = 2'd1;
            4'b00_10: sum = 2'd2;
            4'b01_00: sum = 2'd1;
            4'b01_01: sum = 2'd2;
            4'b01_10: sum = 2'd0;
            4'b10_00: sum = 2'd2;
            4'b10_01: sum = 2'd0;
            4'b10_10: sum = 2'd1;
            default:  sum = 2'd0;
        endcase
        return sum;
    endfunction

endpackage

// File: rtl/zc_slice.sv
// Combinational zero counter for one STEP-bit slice of the word.
module zc_slice #(
    parameter int unsigned STEP = 4,
    localparam int unsigned SW  = $clog2(STEP + 1)
) (
    input  logic [STEP-1:0] bits,
    output logic [SW-1:0]   zeros
);

    // Sum of inverted bits is the number of zeros in the slice.
    always_comb begin
        zeros = '0;
        for (int i = 0; i < STEP; i++) begin
            zeros = zeros + SW'(~bits[i]);
        end
    end

endmodule

// File: rtl/zero_count_seq.sv
// Sequenced zero-count engine: accepts one W-bit word on a valid/ready
// handshake, counts its zeros STEP bits per clock and returns the count
// plus even (X) and multiple-of-3 (Y) flags on a valid/ready handshake.
// Optional build macro: ZC_EARLY_EXIT_EN finishes as soon as every
// still-unexamined bit is 1; results are identical either way.
module zero_count_seq
    import zc_pkg::*;
#(
    parameter int unsigned W     = ZC_DEFAULT_W,
    parameter int unsigned STEP  = ZC_DEFAULT_STEP,
    localparam int unsigned CNT_W = cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_x,
    output logic             out_y,
    output logic             busy
);

    localparam int unsigned NS    = W / STEP;
    localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned SW    = $clog2(STEP + 1);

    zc_state_e        state_q, state_d;
    logic [W-1:0]     shreg_q;
    logic [W-1:0]     shreg_shift;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [1:0]       acc_res_q;
    logic [CNT_W-1:0] cnt_sum;
    logic [1:0]       res_sum;
    logic [SW-1:0]    slice_zeros;
    logic             slice_last;
    logic             accept;
    logic             run_active;

    logic [CNT_W-1:0] count_q;
    logic             x_q;
    logic             y_q;

    zc_slice #(
        .STEP (STEP)
    ) u_slice (
        .bits  (shreg_q[STEP-1:0]),
        .zeros (slice_zeros)
    );

    assign accept     = in_valid && in_ready;
    assign run_active = (state_q == StRun);

    // Ones are shifted in from the top so already-examined positions never
    // look like zeros to the early-exit check.
    assign shreg_shift = (shreg_q >> STEP) | ~({W{1'b1}} >> STEP);

    assign cnt_sum = acc_cnt_q + CNT_W'(slice_zeros);
    assign res_sum = mod3_add(acc_res_q, 4'(slice_zeros));

`ifdef ZC_EARLY_EXIT_EN
    assign slice_last = (idx_q == IDX_W'(NS - 1)) || (&shreg_shift);
`else
    assign slice_last = (idx_q == IDX_W'(NS - 1));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, walk the slices in RUN, wait for the
    // consumer in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid)   state_d = StRun;
            StRun:  if (slice_last) state_d = StDone;
            StDone: if (out_ready)  state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StRun:  busy     = 1'b1;
            StDone: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    // Working datapath: latch on accept, then consume one slice per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            idx_q     <= '0;
            acc_cnt_q <= '0;
            acc_res_q <= '0;
        end else if (accept) begin
            shreg_q   <= in_data;
            idx_q     <= '0;
            acc_cnt_q <= '0;
            acc_res_q <= '0;
        end else if (run_active) begin
            shreg_q   <= shreg_shift;
            idx_q     <= idx_q + IDX_W'(1);
            acc_cnt_q <= cnt_sum;
            acc_res_q <= res_sum;
        end
    end

    // Result registers: loaded on the final slice, held through DONE and
    // IDLE so the last result stays visible until the next one replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
        end else if (run_active && slice_last) begin
            count_q <= cnt_sum;
            x_q     <= ~cnt_sum[0];
            y_q     <= (res_sum == 2'd0);
        end
    end

    assign out_count = count_q;
    assign out_x     = x_q;
    assign out_y     = y_q;

endmodule

// File: tb/tb_zero_count_seq.sv
// Self-checking bench for zero_count_seq: directed cases plus random words
// compared against a bit-counting reference model. Honours ZC_EARLY_EXIT_EN
// when computing the expected latency.
module tb_zero_count_seq;

    localparam int unsigned W     = 16;
    localparam int unsigned STEP  = 4;
    localparam int unsigned NS    = W / STEP;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_x;
    logic             out_y;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zero_count_seq #(
        .W    (W),
        .STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_x     (out_x),
        .out_y     (out_y),
        .busy      (busy)
    );

    function automatic int model_zeros(input logic [W-1:0] d);
        int n = 0;
        for (int i = 0; i < W; i++) if (d[i] == 1'b0) n++;
        return n;
    endfunction

    // Edges from accept to out_valid.
    function automatic int model_latency(input logic [W-1:0] d);
`ifdef ZC_EARLY_EXIT_EN
        int l = 1;
        for (int s = 0; s < NS; s++)
            for (int b = 0; b < STEP; b++)
                if (d[s * STEP + b] == 1'b0) l = s + 1;
        return l;
`else
        return NS;
`endif
    endfunction

    // Full transaction: offer d, check RUN status, latency, result, consume.
    task automatic run_word(input logic [W-1:0] d, input bit early_ready, input string tag);
        int zeros;
        int lat;
        int waited;
        logic [CNT_W-1:0] exp_cnt;
        logic exp_x;
        logic exp_y;
        zeros   = model_zeros(d);
        exp_cnt = CNT_W'(zeros);
        exp_x   = (zeros % 2 == 0);
        exp_y   = (zeros % 3 == 0);

        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = early_ready;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", tag, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s run_status: in_ready=%b busy=%b required 0/1", tag, in_ready, busy);
        end

        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s run_status: in_ready=%b busy=%b required 0/1", tag, in_ready, busy);
            end
        end
        checks++;
        if (lat != model_latency(d)) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", tag, lat, model_latency(d));
        end
        checks++;
        if (out_count !== exp_cnt || out_x !== exp_x || out_y !== exp_y) begin
            errors++;
            $display("FAIL %s result d=%h: count=%0d x=%b y=%b required %0d/%b/%b",
                     tag, d, out_count, out_x, out_y, exp_cnt, exp_x, exp_y);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_status: in_ready=%b busy=%b required 0/1", tag, in_ready, busy);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s idle_after: out_valid=%b in_ready=%b busy=%b count=%0d required 0/1/0/%0d",
                     tag, out_valid, in_ready, busy, out_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 ||
            out_x !== 1'b0 || out_y !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b cnt=%0d x=%b y=%b busy=%b required 1/0/0/0/0/0",
                     in_ready, out_valid, out_count, out_x, out_y, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_word(16'hFFFF, 1'b1, "all_ones");
        run_word(16'h0000, 1'b0, "all_zeros");
        run_word(16'hFFF0, 1'b0, "early_fff0");
        run_word(16'h0FFF, 1'b0, "late_0fff");
    endtask

    task automatic test_back_to_back();
        run_word(16'hFFF8, 1'b1, "b2b_first");
        run_word(16'hFE00, 1'b1, "b2b_second");
    endtask

    task automatic test_backpressure();
        int waited;
        @(negedge clk);
        in_data   = 16'h7FFF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_data = 16'h0000;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: out_valid=%b required 1", out_valid);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_count !== 5'd1 || out_x !== 1'b0 ||
                out_y !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: vld=%b cnt=%0d x=%b y=%b rdy=%b required 1/1/0/0/0",
                         out_valid, out_count, out_x, out_y, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 5'd1) begin
            errors++;
            $display("FAIL bp_release: vld=%b busy=%b cnt=%0d required 0/0/1", out_valid, busy, out_count);
        end
        run_word(16'h0000, 1'b0, "bp_pending");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_data   = 16'h003F;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_count !== '0 ||
            out_x !== 1'b0 || out_y !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: rdy=%b vld=%b cnt=%0d x=%b y=%b busy=%b required 1/0/0/0/0/0",
                     in_ready, out_valid, out_count, out_x, out_y, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_word(16'h003F, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        for (int i = 0; i < 40; i++) begin
            d = W'($urandom);
            if (i % 3 == 0) d = d | W'($urandom);
            if (i % 5 == 0) d = d & W'($urandom);
            run_word(d, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
